// File: rtl/fa_arb_pkg.sv
// Shared constants for the final-adder arbiter: requester identities and the
// default tag width.
package fa_arb_pkg;

  localparam int unsigned TAG_W_DEF = 4;

  typedef enum logic {
    REQ_MUL = 1'b0,
    REQ_MAC = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Holds the priority pointer; a lone eligible
// requester always wins, the pointer only breaks ties.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After a grant the pointer favours the requester that lost this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/final_adder_arb.sv
// Shares one registered CSA-to-binary adder between the multiplier tree and
// the MAC accumulator, routing each result back to its issuer with its tag.
module final_adder_arb
  import fa_arb_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_sum,
  input  logic [31:0]      r0_carry,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_sum,
  input  logic [31:0]      r1_carry,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             fa_v_in,
  output logic [31:0]      fa_sum,
  output logic [31:0]      fa_carry,
  input  logic [31:0]      fa_result,
  input  logic             fa_v_out,
  output logic             d0_valid,
  input  logic             d0_ready,
  output logic [31:0]      d0_result,
  output logic [TAG_W-1:0] d0_tag,
  output logic             d1_valid,
  input  logic             d1_ready,
  output logic [31:0]      d1_result,
  output logic [TAG_W-1:0] d1_tag,
  output logic             err
);

  logic [1:0]       eligible;
  logic [1:0]       grant;

  logic             infl_v_q, infl_v_d;
  req_id_e          infl_id_q, infl_id_d;
  logic [TAG_W-1:0] infl_tag_q, infl_tag_d;

  logic             d0_valid_q, d0_valid_d;
  logic [31:0]      d0_result_q, d0_result_d;
  logic [TAG_W-1:0] d0_tag_q, d0_tag_d;
  logic             d1_valid_q, d1_valid_d;
  logic [31:0]      d1_result_q, d1_result_d;
  logic [TAG_W-1:0] d1_tag_q, d1_tag_d;

  logic             err_q, err_d;
  logic             post_rst_q;
  logic             v_out_seen;
  logic             cap0, cap1;

  // A buffer being drained this cycle is as good as empty.
  always_comb begin
    eligible[0] = ~rst & r0_valid & ~(infl_v_q & (infl_id_q == REQ_MUL))
                  & (~d0_valid_q | d0_ready);
    eligible[1] = ~rst & r1_valid & ~(infl_v_q & (infl_id_q == REQ_MAC))
                  & (~d1_valid_q | d1_ready);
  end

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .advance  (fa_v_in),
    .grant    (grant)
  );

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign fa_v_in  = grant[0] | grant[1];

  always_comb begin
    fa_sum   = 32'd0;
    fa_carry = 32'd0;
    if (grant[0]) begin
      fa_sum   = r0_sum;
      fa_carry = r0_carry;
    end else if (grant[1]) begin
      fa_sum   = r1_sum;
      fa_carry = r1_carry;
    end
  end

  always_comb begin
    infl_v_d   = grant[0] | grant[1];
    infl_id_d  = grant[1] ? REQ_MAC : REQ_MUL;
    infl_tag_d = infl_tag_q;
    if (grant[0]) begin
      infl_tag_d = r0_tag;
    end else if (grant[1]) begin
      infl_tag_d = r1_tag;
    end
  end

  // The adder's v_out is unreset, so it is not trusted in the first cycle
  // after reset release.
  assign v_out_seen = fa_v_out & ~post_rst_q;
  assign cap0       = v_out_seen & infl_v_q & (infl_id_q == REQ_MUL);
  assign cap1       = v_out_seen & infl_v_q & (infl_id_q == REQ_MAC);

  // A capture on the same edge as a drain wins and keeps the buffer full.
  always_comb begin
    d0_valid_d  = d0_valid_q;
    d0_result_d = d0_result_q;
    d0_tag_d    = d0_tag_q;
    if (cap0) begin
      d0_valid_d  = 1'b1;
      d0_result_d = fa_result;
      d0_tag_d    = infl_tag_q;
    end else if (d0_valid_q && d0_ready) begin
      d0_valid_d = 1'b0;
    end
  end

  always_comb begin
    d1_valid_d  = d1_valid_q;
    d1_result_d = d1_result_q;
    d1_tag_d    = d1_tag_q;
    if (cap1) begin
      d1_valid_d  = 1'b1;
      d1_result_d = fa_result;
      d1_tag_d    = infl_tag_q;
    end else if (d1_valid_q && d1_ready) begin
      d1_valid_d = 1'b0;
    end
  end

  // Result presence must track the in-flight flag exactly, in both directions.
  assign err_d = err_q | (v_out_seen ^ infl_v_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_v_q    <= 1'b0;
      infl_id_q   <= REQ_MUL;
      infl_tag_q  <= '0;
      d0_valid_q  <= 1'b0;
      d0_result_q <= 32'd0;
      d0_tag_q    <= '0;
      d1_valid_q  <= 1'b0;
      d1_result_q <= 32'd0;
      d1_tag_q    <= '0;
      err_q       <= 1'b0;
      post_rst_q  <= 1'b1;
    end else begin
      infl_v_q    <= infl_v_d;
      infl_id_q   <= infl_id_d;
      infl_tag_q  <= infl_tag_d;
      d0_valid_q  <= d0_valid_d;
      d0_result_q <= d0_result_d;
      d0_tag_q    <= d0_tag_d;
      d1_valid_q  <= d1_valid_d;
      d1_result_q <= d1_result_d;
      d1_tag_q    <= d1_tag_d;
      err_q       <= err_d;
      post_rst_q  <= 1'b0;
    end
  end

  assign d0_valid  = d0_valid_q;
  assign d0_result = d0_result_q;
  assign d0_tag    = d0_tag_q;
  assign d1_valid  = d1_valid_q;
  assign d1_result = d1_result_q;
  assign d1_tag    = d1_tag_q;
  assign err       = err_q;

endmodule
